alu_fctn_encoder: RTL and testbench

Converts a one-hot ALU operation request into the 3-bit function code that drives the ALU's 3-to-8 function decoder relays, then holds that code stable for a relay settle interval before signalling that it is valid. It sits between the sequencer's operation select lines and the ALU function-code bus. It is the inverse of the function decoder: one-hot in, packed code out. Handshaking on both sides keeps the code unchanged while the relays switch and while the ALU consumes it.

---
 rtl/relay_alu_pkg.sv | 35 +++
 rtl/onehot_to_fctn.sv | 33 +++
 rtl/alu_fctn_encoder.sv | 110 +++++++++++
 tb/tb_alu_fctn_encoder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_alu_pkg.sv
// relay_alu_pkg
// Shared types for the relay ALU function-code path.
//   alu_fctn_t  : the eight 3-bit {f2,f1,f0} codes driven to the 3-to-8
//                 function decoder relays.
//   *_BIT       : bit positions of each operation in the one-hot op_code bus.
//   enc_state_t : states of the function-code encoder handshake FSM.
package relay_alu_pkg;

  typedef enum logic [2:0] {
    FCTN_ADD    = 3'b000,
    FCTN_INC    = 3'b100,
    FCTN_AND    = 3'b010,
    FCTN_OR     = 3'b110,
    FCTN_XOR    = 3'b001,
    FCTN_NOT    = 3'b101,
    FCTN_SHIFTL = 3'b011,
    FCTN_NULL   = 3'b111
  } alu_fctn_t;

  localparam int ADD_BIT    = 7;
  localparam int INC_BIT    = 6;
  localparam int AND_BIT    = 5;
  localparam int OR_BIT     = 4;
  localparam int XOR_BIT    = 3;
  localparam int NOT_BIT    = 2;
  localparam int SHIFTL_BIT = 1;
  localparam int NULL_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } enc_state_t;

endpackage

// File: rtl/onehot_to_fctn.sv
// onehot_to_fctn
// Combinational priority encoder from the one-hot operation request to the
// packed ALU function code. When more than one bit is set the highest
// operation (ADD) wins; an all-zero request encodes as NULL.
// Ports:
//   op_code   in  8  one-hot request, bit layout from relay_alu_pkg
//   fctn      out 3  encoded function code
//   is_onehot out 1  exactly one bit of op_code is set
module onehot_to_fctn
  import relay_alu_pkg::*;
(
  input  logic [7:0] op_code,
  output alu_fctn_t  fctn,
  output logic       is_onehot
);

  // Priority chain, highest operation first.
  always_comb begin
    fctn = FCTN_NULL;
    if (op_code[ADD_BIT])         fctn = FCTN_ADD;
    else if (op_code[INC_BIT])    fctn = FCTN_INC;
    else if (op_code[AND_BIT])    fctn = FCTN_AND;
    else if (op_code[OR_BIT])     fctn = FCTN_OR;
    else if (op_code[XOR_BIT])    fctn = FCTN_XOR;
    else if (op_code[NOT_BIT])    fctn = FCTN_NOT;
    else if (op_code[SHIFTL_BIT]) fctn = FCTN_SHIFTL;
    else if (op_code[NULL_BIT])   fctn = FCTN_NULL;
  end

  // Non-zero with no second bit: clearing the lowest set bit leaves nothing.
  assign is_onehot = (op_code != 8'h00) && ((op_code & (op_code - 8'h01)) == 8'h00);

endmodule

// File: rtl/alu_fctn_encoder.sv
// alu_fctn_encoder
// Turns a one-hot operation request from the sequencer into the 3-bit ALU
// function code, holds it for SETTLE_CYCLES while the decoder relays switch,
// then presents it as valid until the ALU acknowledges it.
// Configuration macro: ALU_ENC_ONEHOT_CHECK_EN
//   defined   - zero or multi-hot requests are dropped with an op_err pulse
//   undefined - no checking, highest set bit wins, op_err stays 0
// Ports:
//   clk         in   1  system clock
//   reset       in   1  synchronous active-high reset
//   op_valid    in   1  request present
//   op_code     in   8  one-hot request
//   op_ready    out  1  encoder idle and able to accept
//   op_err      out  1  one-cycle pulse on a rejected request
//   fctn_code   out  3  registered function code to the relays
//   fctn_valid  out  1  code has settled
//   fctn_ack    in   1  consumer is done with the code
module alu_fctn_encoder
  import relay_alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [7:0] op_code,
  output logic       op_ready,
  output logic       op_err,
  output logic [2:0] fctn_code,
  output logic       fctn_valid,
  input  logic       fctn_ack
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

`ifdef ALU_ENC_ONEHOT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  enc_state_t       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  alu_fctn_t        enc_fctn;
  logic             enc_onehot;
  logic             legal;
  logic             accept;
  logic             reject;

  onehot_to_fctn u_encode (
    .op_code   (op_code),
    .fctn      (enc_fctn),
    .is_onehot (enc_onehot)
  );

  // Without checking every request is legal, so reject can never fire and
  // the op_err flop is held at 0.
  assign legal = CHECK_EN ? enc_onehot : 1'b1;

  // Next-state logic: IDLE takes or rejects a request, SETTLE counts the
  // relay settle time down to zero, HOLD waits for the consumer's ack.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (legal) begin
            accept     = 1'b1;
            count_next = CNT_LOAD;
            state_next = SETTLE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (count == '0) state_next = HOLD;
        else             count_next = count - CNT_W'(1);
      end
      HOLD: begin
        if (fctn_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and output registers. The code register only loads on
  // accept so the relays see a stable value in every other cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      fctn_code <= FCTN_NULL;
      op_err    <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      op_err <= reject;
      if (accept) fctn_code <= enc_fctn;
    end
  end

  assign op_ready   = (state == IDLE);
  assign fctn_valid = (state == HOLD);

endmodule

// File: tb/tb_alu_fctn_encoder.sv
// tb_alu_fctn_encoder
// Self-checking bench for alu_fctn_encoder. Instance u_dut4 uses the default
// settle time of 4 cycles, u_dut1 the minimum of 1 for back-to-back traffic.
// Expected codes come from a bit-index lookup table; expected timing from
// cycle counts between accept, valid and ack. Honours ALU_ENC_ONEHOT_CHECK_EN.
module tb_alu_fctn_encoder;

  localparam int SETTLE_A = 4;
  localparam int SETTLE_B = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       a_op_valid = 1'b0;
  logic [7:0] a_op_code = 8'h00;
  logic       a_op_ready;
  logic       a_op_err;
  logic [2:0] a_fctn_code;
  logic       a_fctn_valid;
  logic       a_fctn_ack = 1'b0;

  logic       b_op_valid = 1'b0;
  logic [7:0] b_op_code = 8'h00;
  logic       b_op_ready;
  logic       b_op_err;
  logic [2:0] b_fctn_code;
  logic       b_fctn_valid;
  logic       b_fctn_ack = 1'b0;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] last_a_code = 3'b111;

  always #5 clk = ~clk;

  alu_fctn_encoder #(.SETTLE_CYCLES(SETTLE_A)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (a_op_valid),
    .op_code    (a_op_code),
    .op_ready   (a_op_ready),
    .op_err     (a_op_err),
    .fctn_code  (a_fctn_code),
    .fctn_valid (a_fctn_valid),
    .fctn_ack   (a_fctn_ack)
  );

  alu_fctn_encoder #(.SETTLE_CYCLES(SETTLE_B)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (b_op_valid),
    .op_code    (b_op_code),
    .op_ready   (b_op_ready),
    .op_err     (b_op_err),
    .fctn_code  (b_fctn_code),
    .fctn_valid (b_fctn_valid),
    .fctn_ack   (b_fctn_ack)
  );

  // Reference encoding: table of codes by op_code bit index, highest set
  // bit wins, nothing set means NULL.
  function automatic logic [2:0] ref_code(input logic [7:0] op);
    logic [2:0] code_of_bit [8];
    logic [2:0] result;
    code_of_bit[7] = 3'b000;
    code_of_bit[6] = 3'b100;
    code_of_bit[5] = 3'b010;
    code_of_bit[4] = 3'b110;
    code_of_bit[3] = 3'b001;
    code_of_bit[2] = 3'b101;
    code_of_bit[1] = 3'b011;
    code_of_bit[0] = 3'b111;
    result = 3'b111;
    for (int i = 0; i < 8; i++)
      if (op[i]) result = code_of_bit[i];
    return result;
  endfunction

  function automatic logic [7:0] rand_onehot();
    logic [7:0] one;
    one = 8'h01;
    return one << $urandom_range(0, 7);
  endfunction

  // One complete request/settle/ack exchange on u_dut4, entered and left
  // #1 after a clock edge with the encoder idle.
  task automatic run_transaction(input logic [7:0] op);
    logic [2:0] exp;
    int n;
    exp = ref_code(op);
    a_op_valid = 1'b1;
    a_op_code  = op;
    @(posedge clk); #1;
    a_op_valid = 1'b0;
    n_checks++;
    if (a_fctn_code !== exp) begin
      n_fail++;
      $display("[TB] FAIL txn_code op=%h: got %b expected %b", op, a_fctn_code, exp);
    end
    n_checks++;
    if (a_op_ready !== 1'b0 || a_fctn_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL txn_busy op=%h: got ready=%b valid=%b expected ready=0 valid=0",
               op, a_op_ready, a_fctn_valid);
    end
    n = 0;
    while (a_fctn_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n != SETTLE_A) begin
      n_fail++;
      $display("[TB] FAIL txn_latency op=%h: got %0d cycles expected %0d", op, n, SETTLE_A);
    end
    a_fctn_ack = 1'b1;
    @(posedge clk); #1;
    a_fctn_ack = 1'b0;
    n_checks++;
    if (a_fctn_valid !== 1'b0 || a_op_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL txn_ack op=%h: got valid=%b ready=%b expected valid=0 ready=1",
               op, a_fctn_valid, a_op_ready);
    end
    last_a_code = exp;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (a_fctn_code !== 3'b111 || a_fctn_valid !== 1'b0 || a_op_ready !== 1'b1 || a_op_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_a: got code=%b valid=%b ready=%b err=%b expected 111/0/1/0",
               a_fctn_code, a_fctn_valid, a_op_ready, a_op_err);
    end
    n_checks++;
    if (b_fctn_code !== 3'b111 || b_fctn_valid !== 1'b0 || b_op_ready !== 1'b1 || b_op_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_b: got code=%b valid=%b ready=%b err=%b expected 111/0/1/0",
               b_fctn_code, b_fctn_valid, b_op_ready, b_op_err);
    end
    last_a_code = 3'b111;
  endtask

  task automatic test_sweep();
    logic [7:0] one;
    one = 8'h01;
    for (int i = 7; i >= 0; i--) run_transaction(one << i);
    for (int k = 0; k < 6; k++) run_transaction(rand_onehot());
  endtask

  task automatic test_stability();
    logic [7:0] op;
    logic [2:0] exp;
    int n;
    op  = rand_onehot();
    exp = ref_code(op);
    a_op_valid = 1'b1;
    a_op_code  = op;
    @(posedge clk); #1;
    a_op_valid = 1'b0;
    n = 0;
    while (a_fctn_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    a_op_code = 8'h08;
    for (int c = 0; c < 20; c++) begin
      a_op_valid = ~a_op_valid;
      @(posedge clk); #1;
      n_checks++;
      if (a_fctn_code !== exp || a_fctn_valid !== 1'b1 || a_op_ready !== 1'b0 || a_op_err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stable cyc=%0d: got code=%b valid=%b ready=%b err=%b expected %b/1/0/0",
                 c, a_fctn_code, a_fctn_valid, a_op_ready, a_op_err, exp);
      end
    end
    a_op_valid = 1'b0;
    a_fctn_ack = 1'b1;
    @(posedge clk); #1;
    a_fctn_ack = 1'b0;
    n_checks++;
    if (a_op_ready !== 1'b1 || a_fctn_code !== exp) begin
      n_fail++;
      $display("[TB] FAIL stable_release: got ready=%b code=%b expected 1/%b", a_op_ready, a_fctn_code, exp);
    end
    last_a_code = exp;
  endtask

  task automatic test_illegal();
    logic [7:0] ops [4];
    logic [7:0] one;
    int i, j;
    one = 8'h01;
    ops[0] = 8'h81;
    ops[1] = 8'h00;
    i = $urandom_range(0, 7);
    j = (i + $urandom_range(1, 7)) % 8;
    ops[2] = (one << i) | (one << j);
    ops[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ENC_ONEHOT_CHECK_EN
      a_op_valid = 1'b1;
      a_op_code  = ops[k];
      @(posedge clk); #1;
      a_op_valid = 1'b0;
      n_checks++;
      if (a_op_err !== 1'b1 || a_op_ready !== 1'b1 || a_fctn_valid !== 1'b0 || a_fctn_code !== last_a_code) begin
        n_fail++;
        $display("[TB] FAIL illegal_reject op=%h: got err=%b ready=%b valid=%b code=%b expected 1/1/0/%b",
                 ops[k], a_op_err, a_op_ready, a_fctn_valid, a_fctn_code, last_a_code);
      end
      @(posedge clk); #1;
      n_checks++;
      if (a_op_err !== 1'b0 || a_op_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL illegal_pulse op=%h: got err=%b ready=%b expected 0/1", ops[k], a_op_err, a_op_ready);
      end
`else
      run_transaction(ops[k]);
`endif
    end
  endtask

  task automatic test_reset_mid_settle();
    logic seen_valid;
    a_op_valid = 1'b1;
    a_op_code  = 8'h04;
    @(posedge clk); #1;
    a_op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (a_fctn_code !== 3'b111 || a_op_ready !== 1'b1 || a_fctn_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got code=%b ready=%b valid=%b expected 111/1/0",
               a_fctn_code, a_op_ready, a_fctn_valid);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (a_fctn_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_valid: got valid seen=%b expected 0", seen_valid);
    end
    last_a_code = 3'b111;
  endtask

  task automatic test_ack_in_idle();
    logic [7:0] op;
    logic [2:0] exp;
    b_fctn_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b_fctn_ack = 1'b0;
    n_checks++;
    if (b_op_ready !== 1'b1 || b_fctn_valid !== 1'b0 || b_fctn_code !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL idle_ack: got ready=%b valid=%b code=%b expected 1/0/111",
               b_op_ready, b_fctn_valid, b_fctn_code);
    end
    op  = rand_onehot();
    exp = ref_code(op);
    b_op_valid = 1'b1;
    b_op_code  = op;
    @(posedge clk); #1;
    b_op_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (b_fctn_valid !== 1'b1 || b_fctn_code !== exp) begin
      n_fail++;
      $display("[TB] FAIL min_settle: got valid=%b code=%b expected 1/%b", b_fctn_valid, b_fctn_code, exp);
    end
    b_fctn_ack = 1'b1;
    @(posedge clk); #1;
    b_fctn_ack = 1'b0;
  endtask

  // Continuous op_valid and ack on the 1-cycle instance: accepts must land
  // exactly SETTLE_B+2 edges apart, each carrying the code driven at that edge.
  task automatic test_back_to_back();
    logic [7:0] pending;
    logic       prev_ready;
    int         cyc, last_cyc, accepts;
    pending    = rand_onehot();
    b_op_code  = pending;
    b_op_valid = 1'b1;
    b_fctn_ack = 1'b1;
    cyc = 0;
    last_cyc = 0;
    accepts = 0;
    while (accepts < 6 && cyc < 60) begin
      prev_ready = b_op_ready;
      @(posedge clk); #1;
      cyc++;
      if (accepts > 0 && cyc == last_cyc + 1) begin
        n_checks++;
        if (b_fctn_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL b2b_valid: got %b expected 1", b_fctn_valid);
        end
      end
      if (prev_ready === 1'b1 && b_op_ready === 1'b0) begin
        n_checks++;
        if (b_fctn_code !== ref_code(pending)) begin
          n_fail++;
          $display("[TB] FAIL b2b_code op=%h: got %b expected %b", pending, b_fctn_code, ref_code(pending));
        end
        if (accepts > 0) begin
          n_checks++;
          if (cyc - last_cyc != SETTLE_B + 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d", cyc - last_cyc, SETTLE_B + 2);
          end
        end
        last_cyc = cyc;
        accepts++;
        pending   = rand_onehot();
        b_op_code = pending;
      end
    end
    b_op_valid = 1'b0;
    b_fctn_ack = 1'b0;
    n_checks++;
    if (accepts != 6) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d accepts expected 6", accepts);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] starting alu_fctn_encoder bench");
    test_reset();
    test_sweep();
    test_stability();
    test_illegal();
    test_reset_mid_settle();
    test_ack_in_idle();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
